// File: rtl/tt_mux_pkg.sv
// tt_mux_pkg: shared controller state encoding and project wrapper bundle widths.
package tt_mux_pkg;
    localparam int IW = 18;
    localparam int OW = 24;
    typedef enum logic [2:0] {OFF, RUN, DRAIN, SWAP, RESET} state_e;
endpackage

// File: rtl/tt_sync2.sv
// tt_sync2: two-flop synchronizer, both stages clear to 0 on reset.
module tt_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[0], d_i};
    assign q_o = sync_q[1];
endmodule

// File: rtl/tt_proj_mux_ctrl.sv
// tt_proj_mux_ctrl: selects one project slot, gating its clock and sequencing drain/swap/reset on every switch.
module tt_proj_mux_ctrl
    import tt_mux_pkg::*;
#(
    parameter int NUM_PROJ     = 8,
    parameter int AW           = 4,
    parameter int RST_CYCLES   = 4,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sel_valid,
    input  logic [AW-1:0]       sel_addr,
    output logic                sel_ready,
    input  logic                user_rst_n,
    output logic [NUM_PROJ-1:0] proj_ena,
    output logic                proj_clk_en,
    output logic                proj_rst_n,
    output logic [AW-1:0]       active_sel,
    output logic                active_valid
);
    localparam int MAXC = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [AW-1:0]        cur_q, cur_d, pend_q, pend_d;
    logic [NUM_PROJ-1:0]  ena_d;
    logic                 user_rst_s, accept, none_in, on, ready_d;

    tt_sync2 u_sync (.clk(clk), .rst_n(rst_n), .d_i(user_rst_n), .q_o(user_rst_s));

    assign accept  = sel_valid && sel_ready;
    assign none_in = sel_addr >= AW'(NUM_PROJ);

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q > CW'(1)) ? cnt_q - CW'(1) : cnt_q;
        cur_d   = cur_q;
        pend_d  = pend_q;
        case (state_q)
            OFF: if (accept && !none_in) begin
                pend_d  = sel_addr;
                cur_d   = sel_addr;
                cnt_d   = CW'(RST_CYCLES);
                state_d = RESET;
            end
            RUN: if (accept) begin
                pend_d  = sel_addr;
                cnt_d   = CW'(DRAIN_CYCLES);
                state_d = DRAIN;
            end
            DRAIN: state_d = (cnt_q == CW'(1)) ? SWAP : DRAIN;
            SWAP: begin
                cur_d   = pend_q;
                cnt_d   = CW'(RST_CYCLES);
                state_d = (pend_q >= AW'(NUM_PROJ)) ? OFF : RESET;
            end
            RESET: state_d = (cnt_q == CW'(1)) ? RUN : RESET;
            default: state_d = OFF;
        endcase
    end

    // Outputs follow the registered state one cycle later; ready rises with active_valid.
    always_comb begin
        on    = (state_q == RUN) || (state_q == DRAIN) || (state_q == RESET);
        ena_d = '0;
        for (int i = 0; i < NUM_PROJ; i++) ena_d[i] = on && (cur_q == AW'(i));
        ready_d = (state_d == OFF) || (state_d == RUN && state_q == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= OFF;
            cnt_q        <= '0;
            cur_q        <= '0;
            pend_q       <= '0;
            sel_ready    <= 1'b1;
            proj_ena     <= '0;
            proj_clk_en  <= 1'b0;
            proj_rst_n   <= 1'b0;
            active_sel   <= '0;
            active_valid <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cur_q        <= cur_d;
            pend_q       <= pend_d;
            sel_ready    <= ready_d;
            proj_ena     <= ena_d;
            proj_clk_en  <= (state_q == RUN) || (state_q == RESET);
            proj_rst_n   <= (state_q == RUN) && user_rst_s;
            active_sel   <= cur_q;
            active_valid <= state_q == RUN;
        end
    end
endmodule

// File: tb/tb_tt_proj_mux_ctrl.sv
// tb_tt_proj_mux_ctrl: directed checks of select, switch, deselect, user reset and async reset.
module tb_tt_proj_mux_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sel_valid = 1'b0;
    logic [3:0] sel_addr = '0;
    logic       sel_ready;
    logic       user_rst_n = 1'b1;
    logic [7:0] proj_ena;
    logic       proj_clk_en;
    logic       proj_rst_n;
    logic [3:0] active_sel;
    logic       active_valid;
    int         checks = 0;
    int         failures = 0;

    tt_proj_mux_ctrl dut (
        .clk(clk), .rst_n(rst_n), .sel_valid(sel_valid), .sel_addr(sel_addr),
        .sel_ready(sel_ready), .user_rst_n(user_rst_n), .proj_ena(proj_ena),
        .proj_clk_en(proj_clk_en), .proj_rst_n(proj_rst_n),
        .active_sel(active_sel), .active_valid(active_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] ena, input logic ce,
                           input logic rn, input logic v, input logic rdy);
        chk({tag, "_ena"}, 32'(proj_ena), 32'(ena));
        chk({tag, "_clken"}, 32'(proj_clk_en), 32'(ce));
        chk({tag, "_rstn"}, 32'(proj_rst_n), 32'(rn));
        chk({tag, "_valid"}, 32'(active_valid), 32'(v));
        chk({tag, "_ready"}, 32'(sel_ready), 32'(rdy));
    endtask

    task automatic sel(input logic [3:0] a);
        sel_valid = 1'b1;
        sel_addr  = a;
        @(posedge clk);
        @(negedge clk);
        sel_valid = 1'b0;
    endtask

    task automatic cold(input string tag, input logic [3:0] a, input logic [7:0] oh);
        sel(a);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk_out($sformatf("%s%0d", tag, k), oh, 1'b1, k == 5, k == 5, k == 5);
        end
        chk({tag, "_sel"}, 32'(active_sel), 32'(a));
    endtask

    task automatic swap(input string tag, input logic [3:0] a, input logic [7:0] old_oh,
                        input logic [7:0] new_oh);
        sel(a);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk_out($sformatf("%s%0d", tag, k), k <= 2 ? old_oh : k == 3 ? 8'h00 : new_oh,
                    k >= 4, k == 8, k == 8, k == 8);
        end
        chk({tag, "_sel"}, 32'(active_sel), 32'(a));
    endtask

    always @(negedge clk) chk("twohot", 32'($countones(proj_ena) > 1), 32'd0);

    initial begin
        int first_low, lows;
        repeat (2) @(negedge clk);
        chk_out("rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_sel", 32'(active_sel), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_out("off", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

        cold("cold", 4'd3, 8'h08);
        swap("sw", 4'd5, 8'h08, 8'h20);

        sel(4'd15);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk_out($sformatf("none%0d", k), k <= 2 ? 8'h20 : 8'h00, 1'b0, 1'b0, 1'b0, k >= 3);
        end
        chk("none_sel", 32'(active_sel), 32'd15);

        cold("recold", 4'd3, 8'h08);
        swap("same", 4'd3, 8'h08, 8'h08);

        user_rst_n = 1'b0;
        first_low  = 0;
        lows       = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (!proj_rst_n) begin
                lows++;
                if (first_low == 0) first_low = i;
            end
            chk($sformatf("urst_ena%0d", i), 32'(proj_ena), 32'h08);
            if (i == 5) user_rst_n = 1'b1;
        end
        chk("urst_lows", 32'(lows), 32'd5);
        chk("urst_lat", 32'(first_low >= 2 && first_low <= 3), 32'd1);
        chk_out("urst_end", 8'h08, 1'b1, 1'b1, 1'b1, 1'b1);

        sel(4'd5);
        @(negedge clk);
        chk_out("drain", 8'h08, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_out("arst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("arst_sel", 32'(active_sel), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_out("post", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
